// File: rtl/line_fetch_scheduler.sv
// Line fetch scheduler: walks a frame line by line, splitting each line into PLB burst reads sized to FIFO room.
// Optional LINE_PREFETCH_EN lets the scheduler run two lines ahead of the display instead of one.
module line_fetch_scheduler #(
    parameter int BURST_WORDS = 16,
    parameter int FIFO_DEPTH  = 256,
    parameter int LEVEL_W     = 9
) (
    input  logic               Bus2IP_Clk,
    input  logic               Bus2IP_Reset,
    input  logic               frame_start,
    input  logic               line_req,
    input  logic               frame_done,
    input  logic [31:0]        frame_base_addr,
    input  logic [31:0]        line_stride,
    input  logic [2:0]         bytes_per_pixel,
    input  logic [10:0]        hres,
    input  logic [9:0]         vres,
    input  logic [LEVEL_W-1:0] fifo_level,
    output logic               mst_rd_req,
    output logic [31:0]        mst_rd_addr,
    output logic [11:0]        mst_rd_len,
    input  logic               mst_cmd_ack,
    input  logic               mst_cmplt,
    input  logic               mst_error,
    output logic               busy,
    output logic [9:0]         line_count,
    output logic               err_overrun,
    output logic               err_bus
);

    // state | meaning
    // IDLE  | no frame active
    // LINE  | between lines, waiting for a line credit
    // SPACE | waiting for FIFO room for the next burst
    // REQ   | burst command presented, waiting for ack
    // WAIT  | burst in flight, waiting for completion
    // DONE  | all lines fetched, waiting for frame_done
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LINE  = 3'd1;
    localparam logic [2:0] S_SPACE = 3'd2;
    localparam logic [2:0] S_REQ   = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [11:0] BURST_BYTES = 12'(BURST_WORDS * 4);
`ifdef LINE_PREFETCH_EN
    localparam logic [1:0] CMAX = 2'd2;
`else
    localparam logic [1:0] CMAX = 2'd1;
`endif

    logic [2:0]  state_q, state_d;
    logic [1:0]  credit_q, credit_d;
    logic [9:0]  line_count_q, line_count_d;
    logic [31:0] line_addr_q, line_addr_d;
    logic [31:0] stride_bytes_q, stride_bytes_d;
    logic [13:0] row_bytes_q, row_bytes_d;
    logic [9:0]  vres_q, vres_d;
    logic [13:0] rem_bytes_q, rem_bytes_d;
    logic [31:0] burst_addr_q, burst_addr_d;
    logic [11:0] burst_len_q, burst_len_d;
    logic        abort_q, abort_d;
    logic        err_overrun_q, err_overrun_d;
    logic        err_bus_q, err_bus_d;

    logic [11:0] cur_len;
    logic [11:0] cur_words;
    logic        room_ok;
    logic        start_ok;
    logic        consume;

    assign cur_len   = (rem_bytes_q > 14'(BURST_BYTES)) ? BURST_BYTES : rem_bytes_q[11:0];
    assign cur_words = (cur_len + 12'd3) >> 2;
    // Widened compare so a level above FIFO_DEPTH never wraps into "room available".
    assign room_ok   = (32'(fifo_level) + 32'(cur_words)) <= 32'(FIFO_DEPTH);
    assign start_ok  = frame_start && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        line_count_d   = line_count_q;
        line_addr_d    = line_addr_q;
        stride_bytes_d = stride_bytes_q;
        row_bytes_d    = row_bytes_q;
        vres_d         = vres_q;
        rem_bytes_d    = rem_bytes_q;
        burst_addr_d   = burst_addr_q;
        burst_len_d    = burst_len_q;
        abort_d        = abort_q;
        err_overrun_d  = err_overrun_q;
        err_bus_d      = err_bus_q;
        consume        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (frame_start) state_d = S_LINE;
            end
            S_LINE: begin
                if (frame_done) begin
                    state_d = S_IDLE;
                end else if ((line_count_q == vres_q) || (row_bytes_q == 14'd0)) begin
                    state_d = S_DONE;
                end else if (credit_q != 2'd0) begin
                    consume      = 1'b1;
                    state_d      = S_SPACE;
                    rem_bytes_d  = row_bytes_q;
                    burst_addr_d = line_addr_q;
                end
            end
            S_SPACE: begin
                if (frame_done) begin
                    state_d = S_IDLE;
                end else if (room_ok) begin
                    state_d     = S_REQ;
                    burst_len_d = cur_len;
                end
            end
            S_REQ: begin
                if (frame_done) abort_d = 1'b1;
                if (mst_cmd_ack) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (frame_done) abort_d = 1'b1;
                if (mst_error) begin
                    err_bus_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (mst_cmplt) begin
                    rem_bytes_d = rem_bytes_q - 14'(burst_len_q);
                    if (abort_q || frame_done) begin
                        state_d = S_IDLE;
                    end else if (rem_bytes_d == 14'd0) begin
                        state_d      = S_LINE;
                        line_count_d = line_count_q + 10'd1;
                        line_addr_d  = line_addr_q + stride_bytes_q;
                    end else begin
                        state_d      = S_SPACE;
                        burst_addr_d = burst_addr_q + 32'(burst_len_q);
                    end
                end
            end
            S_DONE: begin
                if (frame_start) state_d = S_LINE;
                else if (frame_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (start_ok) begin
            line_addr_d    = frame_base_addr;
            stride_bytes_d = line_stride * 32'(bytes_per_pixel);
            row_bytes_d    = 14'(hres) * 14'(bytes_per_pixel);
            vres_d         = vres;
            line_count_d   = 10'd0;
            abort_d        = 1'b0;
        end

        // A line_req that coincides with a line start cancels out.
        if (start_ok) begin
            credit_d = CMAX;
        end else if (line_req && !consume) begin
            if (credit_q == CMAX) err_overrun_d = 1'b1;
            else credit_d = credit_q + 2'd1;
        end else if (!line_req && consume) begin
            credit_d = credit_q - 2'd1;
        end
    end

    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            state_q        <= S_IDLE;
            credit_q       <= 2'd0;
            line_count_q   <= 10'd0;
            line_addr_q    <= 32'd0;
            stride_bytes_q <= 32'd0;
            row_bytes_q    <= 14'd0;
            vres_q         <= 10'd0;
            rem_bytes_q    <= 14'd0;
            burst_addr_q   <= 32'd0;
            burst_len_q    <= 12'd0;
            abort_q        <= 1'b0;
            err_overrun_q  <= 1'b0;
            err_bus_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            line_count_q   <= line_count_d;
            line_addr_q    <= line_addr_d;
            stride_bytes_q <= stride_bytes_d;
            row_bytes_q    <= row_bytes_d;
            vres_q         <= vres_d;
            rem_bytes_q    <= rem_bytes_d;
            burst_addr_q   <= burst_addr_d;
            burst_len_q    <= burst_len_d;
            abort_q        <= abort_d;
            err_overrun_q  <= err_overrun_d;
            err_bus_q      <= err_bus_d;
        end
    end

    assign mst_rd_req  = (state_q == S_REQ);
    assign mst_rd_addr = burst_addr_q;
    assign mst_rd_len  = burst_len_q;
    assign busy        = (state_q != S_IDLE);
    assign line_count  = line_count_q;
    assign err_overrun = err_overrun_q;
    assign err_bus     = err_bus_q;

endmodule
